// File: rtl/regfile_pkg.sv
// Shared constants for the register-file command master: default widths,
// register count, command opcodes and FSM state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;
    localparam int NUM_REGS   = 1 << ADDR_W_DEF;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;
    localparam logic [2:0] ST_CLEAR = 3'd5;

endpackage

// File: rtl/regfile_cmd_master.sv
// Command master for an external register file: accepts WRITE / READ /
// CLEAR / NOP commands, drives the regfile write and read ports, and
// returns read data through a valid/ready response channel.
// Optional feature: define REGFILE_CHECK_EN to add a write-readback CHECK
// state that sets a sticky err_flag when the stored value differs.
module regfile_cmd_master
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_reg_a,
    input  logic [ADDR_W-1:0] cmd_reg_b,
    input  logic [DATA_W-1:0] cmd_data,

    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_writereg,
    output logic [DATA_W-1:0] rf_writedata,
    output logic [ADDR_W-1:0] rf_readreg1,
    output logic [ADDR_W-1:0] rf_readreg2,
    input  logic [DATA_W-1:0] rf_readdata1,
    input  logic [DATA_W-1:0] rf_readdata2,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,

    output logic              busy,
    output logic              err_flag
);

    // The state register itself records which op was accepted, so only
    // the operands need their own holding flops.
    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_a_q,    addr_a_d;
    logic [ADDR_W-1:0] addr_b_q,    addr_b_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
    logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
`ifdef REGFILE_CHECK_EN
    logic              err_q,       err_d;
`endif

    // Next-state and datapath update; CLEAR's counter wraps back to zero
    // on its final address so the next CLEAR starts at register 0.
    always_comb begin
        state_d     = state_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        data_d      = data_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
`ifdef REGFILE_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_a_d = cmd_reg_a;
                    addr_b_d = cmd_reg_b;
                    data_d   = cmd_data;
                    case (cmd_op)
                        OP_WRITE: state_d = ST_WRITE;
                        OP_READ:  state_d = ST_READ;
                        OP_CLEAR: state_d = ST_CLEAR;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
`ifdef REGFILE_CHECK_EN
                state_d = ST_CHECK;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_CHECK: begin
`ifdef REGFILE_CHECK_EN
                if (rf_readdata1 != data_q) begin
                    err_d = 1'b1;
                end
`endif
                state_d = ST_IDLE;
            end
            ST_READ: begin
                rsp_data1_d = rf_readdata1;
                rsp_data2_d = rf_readdata2;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; a reset drops
    // any pending response by returning to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_q      <= '0;
            clr_cnt_q   <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
`ifdef REGFILE_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            data_q      <= data_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
`ifdef REGFILE_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // Regfile port drive; the write strobe is gated by reset so a reset
    // landing mid-WRITE or mid-CLEAR suppresses that cycle's write.
    always_comb begin
        rf_regwrite  = !reset && ((state_q == ST_WRITE) || (state_q == ST_CLEAR));
        rf_writereg  = '0;
        rf_writedata = '0;
        if (state_q == ST_WRITE) begin
            rf_writereg  = addr_a_q;
            rf_writedata = data_q;
        end else if (state_q == ST_CLEAR) begin
            rf_writereg  = clr_cnt_q;
        end
        rf_readreg1 = ((state_q == ST_READ) || (state_q == ST_CHECK)) ? addr_a_q : '0;
        rf_readreg2 = (state_q == ST_READ) ? addr_b_q : '0;
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;

`ifdef REGFILE_CHECK_EN
    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

endmodule
